lsu_bus_ctrl: RTL and testbench
===============================

# lsu_bus_ctrl

Load/store bus controller between the single-cycle datapath and the data memory bus. It accepts the datapath's memory address, store data and load/store request. It turns each request into one registered request/acknowledge bus transaction with byte enables, and stalls the core until the transaction completes. It returns the read word to the datapath already right-aligned for the downstream load sizing/extension logic.

## Interface
Parameters:
- TIMEOUT, 16, cycles in BUSY without ack before abort (used only with LSU_TIMEOUT_EN)

Ports:
- clk  input  1  core clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- mem_rd  input  1  load request from control
- mem_wr  input  1  store request from control
- store_sel  input  2  access size: 00 byte, 01 half, 10 word (11 treated as word)
- addr_to_mem  input  32  byte address from ALU
- data_to_mem  input  32  store data (rs2)
- data_mem_out  output  32  load word, right-shifted by addr[1:0]*8
- stall  output  1  hold PC and inhibit register write
- misalign  output  1  misaligned request, combinational
- bus_err  output  1  transaction aborted by timeout
- bus_req  output  1  bus request, registered
- bus_we  output  1  1 write, 0 read
- bus_addr  output  32  word-aligned address ({addr[31:2],2'b00})
- bus_wdata  output  32  lane-replicated store data
- bus_be  output  4  byte enables
- bus_rdata  input  32  read data, valid with bus_ack
- bus_ack  input  1  transaction complete

## Operation
- States:
  - IDLE: no bus activity.
  - BUSY: bus_req high.
  - DONE: one cycle, result presented.
  - ERR: one cycle, timeout; exists only with LSU_TIMEOUT_EN.
- Request handling:
  - A request is mem_rd|mem_wr. If both are high, the store wins.
  - An aligned request in IDLE latches bus_addr/bus_we/bus_wdata/bus_be and moves to BUSY.
  - stall is high combinationally in IDLE while a request is present, and high throughout BUSY. stall is low in DONE and ERR.
- Misalignment:
  - A half access with addr[0]=1, or a word access with addr[1:0]≠0, asserts misalign.
  - No bus transaction and no stall follow.
  - data_mem_out is 0 for that cycle; the store is dropped.
- BUSY:
  - bus_req and all bus_* outputs stay constant until bus_ack is sampled high at a rising edge.
  - On that edge, a read captures bus_rdata >> (addr[1:0]*8) into data_mem_out; then go to DONE.
- DONE:
  - data_mem_out is held and stall is low, so the instruction retires at the next edge.
  - Always returns to IDLE. A request still present in DONE is not re-issued.
- Store lanes:
  - Byte: wdata={4{d[7:0]}}, be=4'b0001<<addr[1:0].
  - Half: wdata={2{d[15:0]}}, be=addr[1]?4'b1100:4'b0011.
  - Word: wdata=d, be=4'b1111.
- Loads: be=4'b1111, bus_we=0.
- data_mem_out holds its last captured value outside DONE, except that it reads 0 during a misaligned cycle.

## Timing
- Reset (asynchronous, active-low): state IDLE and every registered output 0 (bus_req, bus_we, bus_addr, bus_wdata, bus_be, data_mem_out, bus_err). Assertion mid-transaction drops bus_req immediately.
- Zero-wait ack: cycle 0 IDLE with request, stall=1. Cycle 1 BUSY, bus_req=1, ack=1. Cycle 2 DONE, stall=0. The minimum stall is 2 cycles.
- N wait cycles add N cycles of BUSY.
- bus_ack outside BUSY is ignored.
- misalign and the IDLE stall term are combinational from inputs. All bus_* outputs are registered.

## Configuration
- LSU_TIMEOUT_EN defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - When it reaches TIMEOUT, go to ERR: bus_req drops, bus_err=1 for one cycle, stall=0, data_mem_out=0, then IDLE.
  - An ack on the same edge as the timeout takes priority (normal DONE).
- LSU_TIMEOUT_EN undefined: no counter, BUSY waits indefinitely, bus_err tied 0.

## Structure
- lsu_pkg holds:
  - the state enum (IDLE, BUSY, DONE, ERR)
  - size encodings SZ_B/SZ_H/SZ_W
  - the TIMEOUT default constant
- One sub-module, lsu_lane_align (combinational):
  - store wdata/be generation
  - misalign detection
  - load right-shift

## Test plan
- Word store to 0x100, data 0xDEADBEEF, ack after 2 waits -> bus_addr=0x100, be=1111, wdata=0xDEADBEEF, stall for 4 cycles, then DONE.
- Byte store to 0x103, data 0x000000A5 -> be=1000, wdata=0xA5A5A5A5, bus_we=1.
- Half load from 0x102, bus_rdata=0x1234ABCD, zero-wait ack -> data_mem_out=0x00001234 in DONE, stall 2 cycles.
- Word load from 0x101 -> misalign=1, bus_req stays 0, stall=0, data_mem_out=0.
- Reset asserted in BUSY -> bus_req=0 asynchronously, all outputs 0, state IDLE. After release, a new load completes normally.
- With LSU_TIMEOUT_EN and TIMEOUT=16, no ack -> ERR after 16 BUSY cycles, bus_err pulses 1 cycle, bus_req drops. A late ack is ignored.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store bus controller.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } lsu_state_e;

  // store_sel encodings; 2'b11 is treated as a word access
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam int unsigned LSU_TIMEOUT_DEF = 16;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for the LSU: store data replication, byte enables,
// misalignment detection and right-alignment of the returned load word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        is_store_i,
  input  logic [31:0] st_data_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] ld_word_i,
  output logic [31:0] st_wdata_o,
  output logic [3:0]  be_o,
  output logic        misalign_o,
  output logic [31:0] ld_data_o
);

  always_comb begin
    st_wdata_o = st_data_i;
    be_o       = 4'b1111;
    misalign_o = 1'b0;
    case (size_i)
      SZ_B: begin
        st_wdata_o = {4{st_data_i[7:0]}};
        be_o       = 4'b0001 << addr_lo_i;
      end
      SZ_H: begin
        st_wdata_o = {2{st_data_i[15:0]}};
        be_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        misalign_o = addr_lo_i[0];
      end
      default: misalign_o = |addr_lo_i;
    endcase
    // loads always fetch the whole word; sizing happens downstream
    if (!is_store_i) be_o = 4'b1111;
  end

  assign ld_data_o = ld_word_i >> {ld_off_i, 3'b000};

endmodule

// File: rtl/lsu_bus_ctrl.sv
// Load/store bus controller: one registered req/ack transaction per datapath access.
// Optional bus timeout abort is enabled with the LSU_TIMEOUT_EN macro.
//
//   state | meaning
//   IDLE  | no bus activity, waiting for an aligned request
//   BUSY  | bus_req high, waiting for bus_ack
//   DONE  | one cycle, load result presented, stall released
//   ERR   | one cycle, transaction aborted by timeout (LSU_TIMEOUT_EN only)
module lsu_bus_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = LSU_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [1:0]  store_sel,
  input  logic [31:0] addr_to_mem,
  input  logic [31:0] data_to_mem,
  output logic [31:0] data_mem_out,
  output logic        stall,
  output logic        misalign,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("lsu_bus_ctrl: TIMEOUT must be at least 1");
  end

  lsu_state_e  state_q, state_d;
  logic        req, is_store, mis_raw, issue, ack_hit, timeout_hit;
  logic [31:0] st_wdata, ld_data;
  logic [3:0]  st_be;
  logic        bus_req_q, bus_we_q;
  logic [31:0] bus_addr_q, bus_wdata_q, data_q;
  logic [3:0]  bus_be_q;
  logic [1:0]  off_q;

  assign req      = mem_rd | mem_wr;
  assign is_store = mem_wr;

  lsu_lane_align u_align (
    .size_i     (store_sel),
    .addr_lo_i  (addr_to_mem[1:0]),
    .is_store_i (is_store),
    .st_data_i  (data_to_mem),
    .ld_off_i   (off_q),
    .ld_word_i  (bus_rdata),
    .st_wdata_o (st_wdata),
    .be_o       (st_be),
    .misalign_o (mis_raw),
    .ld_data_o  (ld_data)
  );

  assign issue    = (state_q == IDLE) && req && !mis_raw;
  assign ack_hit  = (state_q == BUSY) && bus_ack;
  assign misalign = (state_q == IDLE) && req && mis_raw;
  assign stall    = issue || (state_q == BUSY);

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmr_q;
  logic          bus_err_q;

  // down-counter loaded on issue; terminal count on the TIMEOUT-th BUSY cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmr_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= timeout_hit;
      if (issue) begin
        tmr_q <= TW'(TIMEOUT - 1);
      end else if ((state_q == BUSY) && !bus_ack && (tmr_q != '0)) begin
        tmr_q <= tmr_q - 1'b1;
      end
    end
  end

  assign timeout_hit = (state_q == BUSY) && !bus_ack && (tmr_q == '0);
  assign bus_err     = bus_err_q;
`else
  assign timeout_hit = 1'b0;
  assign bus_err     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (issue) state_d = BUSY;
      BUSY: begin
        if (bus_ack)          state_d = DONE;
        else if (timeout_hit) state_d = ERR;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_be_q    <= '0;
      off_q       <= '0;
      data_q      <= '0;
    end else begin
      state_q <= state_d;
      if (issue) begin
        bus_req_q   <= 1'b1;
        bus_we_q    <= is_store;
        bus_addr_q  <= {addr_to_mem[31:2], 2'b00};
        bus_wdata_q <= is_store ? st_wdata : '0;
        bus_be_q    <= st_be;
        off_q       <= addr_to_mem[1:0];
      end else if (ack_hit || timeout_hit) begin
        bus_req_q <= 1'b0;
      end
      if (ack_hit && !bus_we_q) begin
        data_q <= ld_data;
      end else if (timeout_hit) begin
        data_q <= '0;
      end
    end
  end

  assign bus_req      = bus_req_q;
  assign bus_we       = bus_we_q;
  assign bus_addr     = bus_addr_q;
  assign bus_wdata    = bus_wdata_q;
  assign bus_be       = bus_be_q;
  assign data_mem_out = misalign ? '0 : data_q;

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Scoreboard bench for lsu_bus_ctrl: driver pushes expectations from a byte-level
// memory model, a monitor pops and compares when the DUT shows bus/stall/misalign events.
module tb_lsu_bus_ctrl;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_rd = 1'b0, mem_wr = 1'b0;
  logic [1:0]  store_sel = 2'b00;
  logic [31:0] addr_to_mem = '0, data_to_mem = '0;
  logic [31:0] data_mem_out;
  logic        stall, misalign, bus_err, bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  always #5 clk = ~clk;

  lsu_bus_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .mem_rd(mem_rd), .mem_wr(mem_wr), .store_sel(store_sel),
    .addr_to_mem(addr_to_mem), .data_to_mem(data_to_mem), .data_mem_out(data_mem_out),
    .stall(stall), .misalign(misalign), .bus_err(bus_err), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  typedef struct { logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata; } bus_exp_t;
  typedef struct { int len; logic [31:0] data; logic err; } res_exp_t;

  bus_exp_t    bus_q[$];
  res_exp_t    res_q[$];
  int          mis_q[$];
  logic [31:0] ref_mem [8];
  logic [31:0] bus_mem [8];
  logic [31:0] last_data = '0;
  int          ack_wait = 0;
  bit          in_reset = 1'b1;
  int          tests = 0, fails = 0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: event seen with nothing expected", name);
  endtask

  // bus-side memory and acknowledge generator; random acks outside transactions
  initial begin
    int cnt;
    cnt = 0;
    bus_ack = 1'b0;
    bus_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus_req) begin
        bus_rdata = bus_mem[bus_addr[4:2]];
        if (cnt == ack_wait && bus_we)
          for (int i = 0; i < 4; i++)
            if (bus_be[i]) bus_mem[bus_addr[4:2]][8*i +: 8] = bus_wdata[8*i +: 8];
        bus_ack = (cnt >= ack_wait);
        cnt++;
      end else begin
        cnt = 0;
        bus_ack = 1'($urandom_range(0, 1));
        bus_rdata = $urandom;
      end
    end
  end

  // monitor
  initial begin
    int       stall_run;
    logic     prev_req;
    bus_exp_t be_e, held;
    res_exp_t re;
    stall_run = 0;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (in_reset) begin
        stall_run = 0;
        prev_req = 1'b0;
        continue;
      end
      if (bus_req && !prev_req) begin
        if (bus_q.size() == 0) note_fail("bus_req_unexpected");
        else begin
          be_e = bus_q.pop_front();
          chk("bus_addr", 72'(bus_addr), 72'(be_e.addr));
          chk("bus_we", 72'(bus_we), 72'(be_e.we));
          chk("bus_be", 72'(bus_be), 72'(be_e.be));
          if (be_e.we) chk("bus_wdata", 72'(bus_wdata), 72'(be_e.wdata));
        end
        held = '{bus_addr, bus_we, bus_be, bus_wdata};
      end else if (bus_req && prev_req) begin
        chk("bus_hold", {bus_addr, bus_wdata, bus_be, 3'b000, bus_we},
                        {held.addr, held.wdata, held.be, 3'b000, held.we});
      end
      prev_req = bus_req;
      if (misalign) begin
        if (mis_q.size() == 0) note_fail("misalign_unexpected");
        else begin
          void'(mis_q.pop_front());
          chk("mis_data_zero", 72'(data_mem_out), 72'(0));
          chk("mis_no_req", 72'(bus_req), 72'(0));
          chk("mis_no_stall", 72'(stall), 72'(0));
        end
      end
      if (stall) stall_run++;
      else if (stall_run > 0) begin
        if (res_q.size() == 0) note_fail("stall_release_unexpected");
        else begin
          re = res_q.pop_front();
          chk("stall_len", 72'(stall_run), 72'(re.len));
          chk("data_mem_out", 72'(data_mem_out), 72'(re.data));
          chk("bus_err", 72'(bus_err), 72'(re.err));
        end
        stall_run = 0;
      end
    end
  end

  task automatic finish_fatal(input string name);
    $display("FAIL %s: bound expired", name);
    fails++;
    tests++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "bench aborted");
  endtask

  // Issue one access; expectations come from the byte-level model. Starts just after a posedge.
  task automatic do_op(input bit rd, input bit wr, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] d, input int waits,
                       input bit timeout_case);
    int          nb, off, w;
    bit          mis, seen;
    bus_exp_t    be_e;
    res_exp_t    re;
    nb  = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    off = int'(a[1:0]);
    w   = int'(a[4:2]);
    mis = (nb == 2 && a[0]) || (nb == 4 && off != 0);
    mem_rd = rd; mem_wr = wr; store_sel = sz; addr_to_mem = a; data_to_mem = d;
    if (mis) begin
      mis_q.push_back(1);
      @(posedge clk); #1;
    end else begin
      be_e.addr = {a[31:2], 2'b00};
      be_e.we = wr;
      for (int i = 0; i < 4; i++) begin
        be_e.be[i] = wr ? (i >= off && i < off + nb) : 1'b1;
        be_e.wdata[8*i +: 8] = wr ? d[8*(i % nb) +: 8] : 8'h00;
      end
      if (wr) begin
        for (int i = off; i < off + nb; i++) ref_mem[w][8*i +: 8] = d[8*(i-off) +: 8];
        re.data = last_data;
      end else begin
        re.data = ref_mem[w] >> (8 * off);
      end
      re.len = 2 + waits;
      re.err = 1'b0;
      if (timeout_case) begin
        re.len = 1 + int'(TO);
        re.data = '0;
        re.err = 1'b1;
      end
      last_data = re.data;
      ack_wait = timeout_case ? 100000 : waits;
      bus_q.push_back(be_e);
      res_q.push_back(re);
      seen = 1'b0;
      for (int k = 0; k < 64; k++) begin
        @(negedge clk);
        if (!stall) begin seen = 1'b1; break; end
      end
      if (!seen) finish_fatal("stall_release_wait");
      @(posedge clk); #1;
    end
    mem_rd = 1'b0; mem_wr = 1'b0;
  endtask

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    int          sel;
    bit          seen;
    for (int i = 0; i < 8; i++) begin
      ref_mem[i] = $urandom;
      bus_mem[i] = ref_mem[i];
    end
    repeat (3) @(negedge clk);
    chk("rst_bus_req", 72'(bus_req), 72'(0));
    chk("rst_regs", {bus_addr, bus_wdata, bus_be, bus_we, bus_err, stall, misalign},
                    72'(0));
    chk("rst_data", 72'(data_mem_out), 72'(0));
    rst = 1'b1;
    @(posedge clk); #1;
    in_reset = 1'b0;

    do_op(0, 1, 2'b10, 32'h100, 32'hDEADBEEF, 2, 0);
    do_op(0, 1, 2'b00, 32'h103, 32'h000000A5, 0, 0);
    do_op(0, 1, 2'b10, 32'h100, 32'h1234ABCD, 1, 0);
    do_op(1, 0, 2'b01, 32'h102, 32'h0, 0, 0);
    do_op(1, 0, 2'b10, 32'h101, 32'h0, 0, 0);
    do_op(0, 1, 2'b01, 32'h105, 32'hCAFEF00D, 0, 0);
    do_op(1, 1, 2'b11, 32'h104, 32'h0BADC0DE, 1, 0);
    do_op(1, 0, 2'b10, 32'h100, 32'h0, 3, 0);

    // asynchronous reset in the middle of a transaction
    ack_wait = 6;
    bus_q.push_back('{32'h108, 1'b0, 4'hF, 32'h0});
    mem_rd = 1'b1; store_sel = 2'b10; addr_to_mem = 32'h108;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus_req) begin seen = 1'b1; break; end
    end
    if (!seen) finish_fatal("bus_req_wait");
    @(posedge clk); #2;
    in_reset = 1'b1;
    rst = 1'b0;
    mem_rd = 1'b0;
    #1;
    chk("arst_bus_req", 72'(bus_req), 72'(0));
    chk("arst_bus_addr", 72'(bus_addr), 72'(0));
    chk("arst_bus_be", 72'(bus_be), 72'(0));
    chk("arst_misc", {bus_wdata, bus_we, bus_err, stall}, 72'(0));
    chk("arst_data", 72'(data_mem_out), 72'(0));
    last_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    in_reset = 1'b0;
    do_op(1, 0, 2'b10, 32'h108, 32'h0, 1, 0);

`ifdef LSU_TIMEOUT_EN
    do_op(1, 0, 2'b10, 32'h10C, 32'h0, 0, 1);
    repeat (2) @(posedge clk); #1;
    do_op(1, 0, 2'b00, 32'h10D, 32'h0, 0, 0);
`endif

    for (int n = 0; n < 200; n++) begin
      sz = 2'($urandom_range(0, 3));
      a = 32'h100 + $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) begin
        if (sz == 2'b01) a[0] = 1'b0;
        else if (sz[1]) a[1:0] = 2'b00;
      end
      sel = $urandom_range(0, 9);
      do_op(sel < 5 || sel == 9, sel >= 5, sz, a, $urandom, $urandom_range(0, 3), 0);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end

    repeat (5) @(posedge clk);
    chk("bus_q_drained", 72'(bus_q.size()), 72'(0));
    chk("res_q_drained", 72'(res_q.size()), 72'(0));
    chk("mis_q_drained", 72'(mis_q.size()), 72'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
